// File: rtl/dac_spi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_driver
//  Description : Writes two 12-bit waveform samples to a dual-channel SPI DAC
//                (SPI mode 0, MSB first). Channel A frame, chip-select gap,
//                channel B frame, gap, then an optional LDAC strobe.
//                Optional feature macro: DAC_SPI_LDAC_EN (LDAC strobe state;
//                when undefined ldac_n is tied low and each channel updates on
//                its own chip-select rising edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_driver #(
    parameter int SCLK_DIV = 4,
    parameter int CS_GAP   = 2
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        ds_start_i,
    input  logic [11:0] ds_wave_1_i,
    input  logic [11:0] ds_wave_2_i,
    output logic        ds_busy_o,
    output logic        ds_done_o,
    output logic        ds_sclk_o,
    output logic        ds_mosi_o,
    output logic        ds_cs_n_o,
    output logic        ds_ldac_n_o
);

    // The gap counter also times the 2-cycle LDAC strobe, so it must reach 1.
    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int GAP_W = $clog2(CS_GAP + 2);

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_one   = DIV_W'(1);
    localparam logic [GAP_W-1:0] c_gap_last  = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0] c_gap_one   = GAP_W'(1);
    // BUF off, gain 1x, DAC active
    localparam logic [2:0]       c_frame_ctl = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT_A = 3'd1,
        S_GAP_A   = 3'd2,
        S_SHIFT_B = 3'd3,
        S_GAP_B   = 3'd4,
        S_LDAC    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_done_next;
    logic [15:0]      r_shift;
    logic [11:0]      r_wave_b;
    logic [3:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_sclk;
    logic             r_done;
    logic             w_shifting;
    logic             w_half_end;
    logic             w_frame_end;
    logic             w_gap_end;

    assign w_shifting  = (r_state == S_SHIFT_A) || (r_state == S_SHIFT_B);
    assign w_half_end  = (r_div_cnt == c_div_last);
    // Frame ends when the high phase of bit 0 expires
    assign w_frame_end = w_shifting && r_sclk && w_half_end && (r_bit_cnt == 4'd0);
    assign w_gap_end   = (r_gap_cnt == c_gap_last);

    assign ds_busy_o   = (r_state != S_IDLE);
    assign ds_done_o   = r_done;
    assign ds_sclk_o   = r_sclk;
    assign ds_mosi_o   = w_shifting & r_shift[15];
    assign ds_cs_n_o   = ~w_shifting;
`ifdef DAC_SPI_LDAC_EN
    assign ds_ldac_n_o = (r_state != S_LDAC);
`else
    assign ds_ldac_n_o = 1'b0;
`endif

    // Next-state decode and completion pulse
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ds_start_i) w_state_next = S_SHIFT_A;
            end
            S_SHIFT_A: begin
                if (w_frame_end) w_state_next = S_GAP_A;
            end
            S_GAP_A: begin
                if (w_gap_end) w_state_next = S_SHIFT_B;
            end
            S_SHIFT_B: begin
                if (w_frame_end) w_state_next = S_GAP_B;
            end
            S_GAP_B: begin
                if (w_gap_end) begin
`ifdef DAC_SPI_LDAC_EN
                    w_state_next = S_LDAC;
`else
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
`endif
                end
            end
`ifdef DAC_SPI_LDAC_EN
            S_LDAC: begin
                if (r_gap_cnt == c_gap_one) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register, sample latches, bit/divider/gap counters
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_shift   <= '0;
            r_wave_b  <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            case (r_state)
                S_IDLE: begin
                    if (ds_start_i) begin
                        r_shift   <= {1'b0, c_frame_ctl, ds_wave_1_i};
                        r_wave_b  <= ds_wave_2_i;
                        r_bit_cnt <= 4'd15;
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b0;
                    end
                end
                S_SHIFT_A, S_SHIFT_B: begin
                    r_gap_cnt <= '0;
                    if (w_half_end) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        // Advance to the next bit only after the high phase
                        if (r_sclk) begin
                            r_bit_cnt <= r_bit_cnt - 4'd1;
                            r_shift   <= {r_shift[14:0], 1'b0};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_div_one;
                    end
                end
                S_GAP_A: begin
                    if (w_gap_end) begin
                        r_shift   <= {1'b1, c_frame_ctl, r_wave_b};
                        r_bit_cnt <= 4'd15;
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_one;
                    end
                end
`ifdef DAC_SPI_LDAC_EN
                S_LDAC: begin
                    r_gap_cnt <= r_gap_cnt + c_gap_one;
                end
`endif
                default: begin
                    r_gap_cnt <= w_gap_end ? '0 : (r_gap_cnt + c_gap_one);
                end
            endcase
        end
    end

endmodule
`default_nettype wire
